axi_mem_arbiter: RTL and testbench
==================================

# axi_mem_arbiter

Two-master to one-slave arbiter for the NPC memory port: master 0 is the IFU (read-only), master 1 is the LSU (read and write), and the slave is the single AXI-lite-style data memory port (32-bit address, 64-bit data, single-beat). One transaction is in flight at a time. Request addresses and data are registered on grant. Response channels pass through combinationally to the granted master.

## Interface
- Parameters: none. Widths are fixed: address 32, data 64, strobe 8, resp 2.
- Ports (all `m0_`/`m1_` ports face masters, `s_` ports face the slave):
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `m0_araddr` in 32, `m0_arvalid` in 1, `m0_arready` out 1: IFU read address.
- `m0_rdata` out 64, `m0_rresp` out 2, `m0_rvalid` out 1, `m0_rready` in 1: IFU read data.
- `m1_araddr` in 32, `m1_arvalid` in 1, `m1_arready` out 1: LSU read address.
- `m1_rdata` out 64, `m1_rresp` out 2, `m1_rvalid` out 1, `m1_rready` in 1: LSU read data.
- `m1_awaddr` in 32, `m1_awvalid` in 1, `m1_awready` out 1: LSU write address.
- `m1_wdata` in 64, `m1_wstrb` in 8, `m1_wvalid` in 1, `m1_wready` out 1: LSU write data.
- `m1_bresp` out 2, `m1_bvalid` out 1, `m1_bready` in 1: LSU write response.
- `s_araddr` out 32, `s_arvalid` out 1, `s_arready` in 1: slave read address.
- `s_rdata` in 64, `s_rresp` in 2, `s_rvalid` in 1, `s_rready` out 1: slave read data.
- `s_awaddr` out 32, `s_awvalid` out 1, `s_awready` in 1: slave write address.
- `s_wdata` out 64, `s_wstrb` out 8, `s_wvalid` out 1, `s_wready` in 1: slave write data.
- `s_bresp` in 2, `s_bvalid` in 1, `s_bready` out 1: slave write response.

## Operation
- FSM states: IDLE, RADDR, RDATA, WREQ, WRESP. The grant register `gnt` is 0 or 1.
- IDLE arbitration (fixed priority), evaluated in the same cycle the requests are seen:
  - First: LSU write, only when `m1_awvalid` and `m1_wvalid` are both high.
  - Second: LSU read (`m1_arvalid`).
  - Third: IFU read (`m0_arvalid`).
  - An LSU write with only one of awvalid/wvalid high is not granted and does not block reads.
- On a read grant:
  - The winner's `arready` is high for exactly that IDLE cycle.
  - The address is latched and `gnt` is set.
  - Next state is RADDR.
- RADDR: `s_arvalid`=1 with the latched address. On `s_arready` go to RDATA.
- RDATA:
  - `s_rready` = granted master's `rready`.
  - Granted master's `rvalid`/`rdata`/`rresp` = slave's values. The other master sees `rvalid`=0 and `rdata`/`rresp`=0.
  - On `s_rvalid & s_rready` return to IDLE.
- On a write grant:
  - `m1_awready` and `m1_wready` are high together for that IDLE cycle.
  - Address, data and strobe are latched, and the aw_done/w_done flags are cleared.
  - Next state is WREQ.
- WREQ:
  - `s_awvalid` = !aw_done and `s_wvalid` = !w_done. Each flag sets on its own handshake.
  - The two handshakes may complete in either order or in the same cycle.
  - Go to WRESP in the cycle both are complete, counting a handshake in the current cycle.
- WRESP:
  - `s_bready` = `m1_bready`; `m1_bvalid`/`m1_bresp` = slave's values.
  - On handshake return to IDLE.
- No `*ready` toward masters is asserted outside IDLE. New requests wait.
- Slave responses are not inspected. SLVERR/DECERR pass through unchanged.

## Timing
- Reset: state IDLE, `gnt`=0, all latched address/data/strobe registers 0, aw_done=w_done=0, round-robin pointer 0. Every output port is 0 during and after reset until a grant.
- Reset mid-transaction aborts it: state returns to IDLE the next cycle and the slave valids drop. No response is forwarded.
- Read, with zero-wait slave (`s_arready` and `s_rvalid` high immediately):
  - cycle 0: grant / `m*_arready`.
  - cycle 1: `s_arvalid`.
  - cycle 2: `rvalid` to master.
  - cycle 3: IDLE, new grant possible.
- Write, with zero-wait slave:
  - cycle 0: grant.
  - cycle 1: `s_awvalid` + `s_wvalid`.
  - cycle 2: `m1_bvalid`.
  - cycle 3: IDLE.
- Masters hold valid and address until they see ready; the arbiter relies on this.

## Configuration
- `ARB_RR_EN` undefined: fixed priority as above.
- `ARB_RR_EN` defined: read arbitration between m0 and m1 is round-robin.
  - A 1-bit pointer names the preferred master; reset value is 0 (IFU).
  - On each read grant the pointer is set to the other master.
  - The LSU write still has highest priority and does not change the pointer.

## Test plan
- Reset: hold `rst`=1 three cycles with all valids high → all outputs 0, no `arready`/`awready` during reset.
- IFU read: `m0_araddr`=0x80000000, zero-wait slave returning `s_rdata`=0x1122334455667788 → `m0_arready` cycle 0, `s_araddr`=0x80000000 cycle 1, `m0_rvalid` with that data cycle 2, `m1_rvalid`=0.
- Contention: `m0_arvalid` and `m1_arvalid` both high continuously.
  - Without `ARB_RR_EN`: m1 always wins.
  - With `ARB_RR_EN`: the first grant goes to m0, then grants alternate m1, m0, m1.
- Write split handshake: `m1_awaddr`=0x80001000, `m1_wdata`=0xDEADBEEF, `m1_wstrb`=0x0F; slave `s_wready` 1 cycle before `s_awready` → `s_wvalid` drops after its handshake, `s_awvalid` holds, `m1_bvalid` only after both handshakes.
- Priority and partial write: `m1_awvalid`=1 with `m1_wvalid`=0, plus `m0_arvalid`=1 → m0 read granted; raising `m1_wvalid` later yields a write grant at the next IDLE ahead of a pending m0 read.
- Backpressure and reset: `m0_rready`=0 for 5 cycles while `s_rvalid`=1 → state stays RDATA, `s_rready`=0. Assert `rst` mid-RDATA → IDLE next cycle, `m0_rvalid`=0.

Source files
------------

// File: rtl/axi_mem_arbiter.sv
// ---------------------------------------------------------------------------
// axi_mem_arbiter
//
// Two-master to one-slave arbiter for the NPC memory port. Master 0 is the
// IFU and can only read. Master 1 is the LSU and can read and write. The
// slave is a single-beat AXI-lite-style memory port with a 32-bit address
// and 64-bit data. Only one transaction is in flight at a time.
//
// Request address, data and strobe are registered on grant. Responses
// (rdata/rresp/rvalid and bresp/bvalid) pass combinationally from the slave
// to the granted master.
//
// Optional feature macro: ARB_RR_EN
//   undefined : reads use fixed priority, LSU read over IFU read.
//   defined   : reads between IFU and LSU are round-robin. An LSU write
//               still has top priority and does not move the pointer.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   m0_ar* / m0_r*                 IFU read address / read data
//   m1_ar* / m1_r*                 LSU read address / read data
//   m1_aw* / m1_w* / m1_b*         LSU write address / data / response
//   s_ar* / s_r*                   slave read address / read data
//   s_aw* / s_w* / s_b*            slave write address / data / response
// ---------------------------------------------------------------------------
module axi_mem_arbiter (
    input  logic        clk,
    input  logic        rst,
    // IFU read
    input  logic [31:0] m0_araddr,
    input  logic        m0_arvalid,
    output logic        m0_arready,
    output logic [63:0] m0_rdata,
    output logic [1:0]  m0_rresp,
    output logic        m0_rvalid,
    input  logic        m0_rready,
    // LSU read
    input  logic [31:0] m1_araddr,
    input  logic        m1_arvalid,
    output logic        m1_arready,
    output logic [63:0] m1_rdata,
    output logic [1:0]  m1_rresp,
    output logic        m1_rvalid,
    input  logic        m1_rready,
    // LSU write
    input  logic [31:0] m1_awaddr,
    input  logic        m1_awvalid,
    output logic        m1_awready,
    input  logic [63:0] m1_wdata,
    input  logic [7:0]  m1_wstrb,
    input  logic        m1_wvalid,
    output logic        m1_wready,
    output logic [1:0]  m1_bresp,
    output logic        m1_bvalid,
    input  logic        m1_bready,
    // slave
    output logic [31:0] s_araddr,
    output logic        s_arvalid,
    input  logic        s_arready,
    input  logic [63:0] s_rdata,
    input  logic [1:0]  s_rresp,
    input  logic        s_rvalid,
    output logic        s_rready,
    output logic [31:0] s_awaddr,
    output logic        s_awvalid,
    input  logic        s_awready,
    output logic [63:0] s_wdata,
    output logic [7:0]  s_wstrb,
    output logic        s_wvalid,
    input  logic        s_wready,
    input  logic [1:0]  s_bresp,
    input  logic        s_bvalid,
    output logic        s_bready
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RADDR = 3'd1,
        RDATA = 3'd2,
        WREQ  = 3'd3,
        WRESP = 3'd4
    } state_e;

    state_e      state_q;
    logic        gnt_q;
    logic [31:0] addr_q;
    logic [63:0] wdata_q;
    logic [7:0]  wstrb_q;
    logic        aw_done_q;
    logic        w_done_q;
`ifdef ARB_RR_EN
    logic        rr_ptr_q;
`endif

    // Every output is forced low while reset is asserted, including the
    // cycle in which reset is first seen mid-transaction.
    logic active;
    assign active = !rst;

    logic in_idle, in_raddr, in_rdata, in_wreq, in_wresp;
    assign in_idle  = active && (state_q == IDLE);
    assign in_raddr = active && (state_q == RADDR);
    assign in_rdata = active && (state_q == RDATA);
    assign in_wreq  = active && (state_q == WREQ);
    assign in_wresp = active && (state_q == WRESP);

    // ---------------- arbitration (combinational, IDLE only) --------------
    // A write needs both address and data valid; a half-presented write
    // neither wins nor blocks reads.
    logic wr_req, rd_pick_m1, grant_wr, grant_rd;
    assign wr_req = m1_awvalid && m1_wvalid;
`ifdef ARB_RR_EN
    assign rd_pick_m1 = m1_arvalid && (!m0_arvalid || rr_ptr_q);
`else
    assign rd_pick_m1 = m1_arvalid;
`endif
    assign grant_wr = in_idle && wr_req;
    assign grant_rd = in_idle && !wr_req && (m0_arvalid || m1_arvalid);

    assign m1_awready = grant_wr;
    assign m1_wready  = grant_wr;
    assign m1_arready = grant_rd && rd_pick_m1;
    assign m0_arready = grant_rd && !rd_pick_m1;

    // ---------------- slave request side ----------------------------------
    assign s_araddr  = active ? addr_q  : 32'd0;
    assign s_awaddr  = active ? addr_q  : 32'd0;
    assign s_wdata   = active ? wdata_q : 64'd0;
    assign s_wstrb   = active ? wstrb_q : 8'd0;
    assign s_arvalid = in_raddr;
    assign s_awvalid = in_wreq && !aw_done_q;
    assign s_wvalid  = in_wreq && !w_done_q;

    // ---------------- response passthrough --------------------------------
    logic rd_m0, rd_m1;
    assign rd_m0 = in_rdata && !gnt_q;
    assign rd_m1 = in_rdata &&  gnt_q;

    assign s_rready  = (rd_m0 && m0_rready) || (rd_m1 && m1_rready);
    assign m0_rvalid = rd_m0 && s_rvalid;
    assign m0_rdata  = rd_m0 ? s_rdata : 64'd0;
    assign m0_rresp  = rd_m0 ? s_rresp : 2'd0;
    assign m1_rvalid = rd_m1 && s_rvalid;
    assign m1_rdata  = rd_m1 ? s_rdata : 64'd0;
    assign m1_rresp  = rd_m1 ? s_rresp : 2'd0;

    assign s_bready  = in_wresp && m1_bready;
    assign m1_bvalid = in_wresp && s_bvalid;
    assign m1_bresp  = in_wresp ? s_bresp : 2'd0;

    // Handshakes in the current WREQ cycle count toward completion so a
    // same-cycle aw/w pair moves straight to WRESP.
    logic aw_hs, w_hs;
    assign aw_hs = s_awvalid && s_awready;
    assign w_hs  = s_wvalid  && s_wready;

    // ---------------- state ------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            gnt_q     <= 1'b0;
            addr_q    <= 32'd0;
            wdata_q   <= 64'd0;
            wstrb_q   <= 8'd0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
`ifdef ARB_RR_EN
            rr_ptr_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_wr) begin
                        addr_q    <= m1_awaddr;
                        wdata_q   <= m1_wdata;
                        wstrb_q   <= m1_wstrb;
                        gnt_q     <= 1'b1;
                        aw_done_q <= 1'b0;
                        w_done_q  <= 1'b0;
                        state_q   <= WREQ;
                    end else if (grant_rd) begin
                        addr_q  <= rd_pick_m1 ? m1_araddr : m0_araddr;
                        gnt_q   <= rd_pick_m1;
`ifdef ARB_RR_EN
                        rr_ptr_q <= !rd_pick_m1;
`endif
                        state_q <= RADDR;
                    end
                end
                RADDR: begin
                    if (s_arready) state_q <= RDATA;
                end
                RDATA: begin
                    if (s_rvalid && s_rready) state_q <= IDLE;
                end
                WREQ: begin
                    if (aw_hs) aw_done_q <= 1'b1;
                    if (w_hs)  w_done_q  <= 1'b1;
                    if ((aw_done_q || aw_hs) && (w_done_q || w_hs))
                        state_q <= WRESP;
                end
                WRESP: begin
                    if (s_bvalid && m1_bready) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_mem_arbiter.sv
module tb_axi_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] m0_araddr;  logic m0_arvalid; logic m0_arready;
    logic [63:0] m0_rdata;   logic [1:0] m0_rresp; logic m0_rvalid; logic m0_rready;
    logic [31:0] m1_araddr;  logic m1_arvalid; logic m1_arready;
    logic [63:0] m1_rdata;   logic [1:0] m1_rresp; logic m1_rvalid; logic m1_rready;
    logic [31:0] m1_awaddr;  logic m1_awvalid; logic m1_awready;
    logic [63:0] m1_wdata;   logic [7:0] m1_wstrb; logic m1_wvalid; logic m1_wready;
    logic [1:0]  m1_bresp;   logic m1_bvalid; logic m1_bready;
    logic [31:0] s_araddr;   logic s_arvalid; logic s_arready;
    logic [63:0] s_rdata;    logic [1:0] s_rresp; logic s_rvalid; logic s_rready;
    logic [31:0] s_awaddr;   logic s_awvalid; logic s_awready;
    logic [63:0] s_wdata;    logic [7:0] s_wstrb; logic s_wvalid; logic s_wready;
    logic [1:0]  s_bresp;    logic s_bvalid; logic s_bready;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    axi_mem_arbiter dut (
        .clk(clk), .rst(rst),
        .m0_araddr(m0_araddr), .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
        .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
        .m1_araddr(m1_araddr), .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
        .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
        .m1_awaddr(m1_awaddr), .m1_awvalid(m1_awvalid), .m1_awready(m1_awready),
        .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_wvalid(m1_wvalid), .m1_wready(m1_wready),
        .m1_bresp(m1_bresp), .m1_bvalid(m1_bvalid), .m1_bready(m1_bready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready)
    );

    // OR of every output bit: zero means all outputs are low.
    logic any_out;
    assign any_out = |{m0_arready, m0_rdata, m0_rresp, m0_rvalid,
                       m1_arready, m1_rdata, m1_rresp, m1_rvalid,
                       m1_awready, m1_wready, m1_bresp, m1_bvalid,
                       s_araddr, s_arvalid, s_rready, s_awaddr, s_awvalid,
                       s_wdata, s_wstrb, s_wvalid, s_bready};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change just after the falling edge; checks run 1 ns later,
    // well clear of the rising edge.
    task automatic nxt();
        @(negedge clk);
    endtask

    logic exp_m1;

    initial begin
        rst = 1'b1;
        m0_araddr = '0; m0_arvalid = 0; m0_rready = 0;
        m1_araddr = '0; m1_arvalid = 0; m1_rready = 0;
        m1_awaddr = '0; m1_awvalid = 0; m1_wdata = '0; m1_wstrb = '0; m1_wvalid = 0; m1_bready = 0;
        s_arready = 0; s_rdata = '0; s_rresp = '0; s_rvalid = 0;
        s_awready = 0; s_wready = 0; s_bresp = '0; s_bvalid = 0;

        // ---- reset with every valid high ----
        nxt();
        m0_arvalid = 1; m1_arvalid = 1; m1_awvalid = 1; m1_wvalid = 1;
        s_rvalid = 1; s_bvalid = 1; s_arready = 1; s_awready = 1; s_wready = 1;
        m0_rready = 1; m1_rready = 1; m1_bready = 1;
        for (int i = 0; i < 3; i++) begin
            #1 chk("reset_outputs_zero", 64'(any_out), 64'd0);
            nxt();
        end
        rst = 0;
        m0_arvalid = 0; m1_arvalid = 0; m1_awvalid = 0; m1_wvalid = 0;
        s_rvalid = 0; s_bvalid = 0;
        #1 chk("post_reset_outputs_zero", 64'(any_out), 64'd0);

        // ---- contention: both reads held high, zero-wait slave ----
        nxt();
        m0_araddr = 32'h000000A0; m1_araddr = 32'h000000B0;
        m0_arvalid = 1; m1_arvalid = 1; s_rvalid = 1;
        s_rdata = 64'h0000_0000_CAFE_0001;
        for (int g = 0; g < 4; g++) begin
`ifdef ARB_RR_EN
            exp_m1 = (g % 2) == 1;
`else
            exp_m1 = 1'b1;
`endif
            #1;
            chk("contend_m1_arready", 64'(m1_arready), 64'(exp_m1));
            chk("contend_m0_arready", 64'(m0_arready), 64'(!exp_m1));
            nxt();
            #1 chk("contend_s_araddr", 64'(s_araddr), exp_m1 ? 64'hB0 : 64'hA0);
            nxt();
            #1;
            chk("contend_m1_rvalid", 64'(m1_rvalid), 64'(exp_m1));
            chk("contend_m0_rvalid", 64'(m0_rvalid), 64'(!exp_m1));
            nxt();
        end
        m0_arvalid = 0; m1_arvalid = 0; s_rvalid = 0;

        // ---- IFU read, zero-wait slave ----
        nxt();
        m0_araddr = 32'h8000_0000; m0_arvalid = 1;
        s_rvalid = 1; s_rdata = 64'h1122_3344_5566_7788; s_rresp = 2'b00;
        #1;
        chk("ifu_arready_c0", 64'(m0_arready), 64'd1);
        chk("ifu_m1_arready_c0", 64'(m1_arready), 64'd0);
        chk("ifu_s_arvalid_c0", 64'(s_arvalid), 64'd0);
        nxt();
        m0_arvalid = 0;
        #1;
        chk("ifu_s_arvalid_c1", 64'(s_arvalid), 64'd1);
        chk("ifu_s_araddr_c1", 64'(s_araddr), 64'h8000_0000);
        chk("ifu_m0_rvalid_c1", 64'(m0_rvalid), 64'd0);
        nxt();
        #1;
        chk("ifu_m0_rvalid_c2", 64'(m0_rvalid), 64'd1);
        chk("ifu_m0_rdata_c2", m0_rdata, 64'h1122_3344_5566_7788);
        chk("ifu_m1_rvalid_c2", 64'(m1_rvalid), 64'd0);
        chk("ifu_m1_rdata_c2", m1_rdata, 64'd0);
        chk("ifu_s_rready_c2", 64'(s_rready), 64'd1);
        nxt();
        s_rvalid = 0;
        #1;
        chk("ifu_idle_c3_rvalid", 64'(m0_rvalid), 64'd0);
        chk("ifu_idle_c3_arvalid", 64'(s_arvalid), 64'd0);

        // ---- write with split handshakes ----
        nxt();
        m1_awaddr = 32'h8000_1000; m1_wdata = 64'h0000_0000_DEAD_BEEF; m1_wstrb = 8'h0F;
        m1_awvalid = 1; m1_wvalid = 1; s_awready = 0; s_wready = 0;
        #1;
        chk("wr_awready_c0", 64'(m1_awready), 64'd1);
        chk("wr_wready_c0", 64'(m1_wready), 64'd1);
        nxt();
        m1_awvalid = 0; m1_wvalid = 0; s_wready = 1; s_bvalid = 1; s_bresp = 2'b10;
        #1;
        chk("wr_s_awvalid_c1", 64'(s_awvalid), 64'd1);
        chk("wr_s_wvalid_c1", 64'(s_wvalid), 64'd1);
        chk("wr_s_awaddr_c1", 64'(s_awaddr), 64'h8000_1000);
        chk("wr_s_wdata_c1", s_wdata, 64'h0000_0000_DEAD_BEEF);
        chk("wr_s_wstrb_c1", 64'(s_wstrb), 64'h0F);
        chk("wr_bvalid_c1", 64'(m1_bvalid), 64'd0);
        nxt();
        s_wready = 0; s_awready = 1;
        #1;
        chk("wr_s_wvalid_c2", 64'(s_wvalid), 64'd0);
        chk("wr_s_awvalid_c2", 64'(s_awvalid), 64'd1);
        chk("wr_bvalid_c2", 64'(m1_bvalid), 64'd0);
        nxt();
        s_awready = 0;
        #1;
        chk("wr_bvalid_c3", 64'(m1_bvalid), 64'd1);
        chk("wr_bresp_c3", 64'(m1_bresp), 64'd2);
        chk("wr_s_bready_c3", 64'(s_bready), 64'd1);
        chk("wr_s_awvalid_c3", 64'(s_awvalid), 64'd0);
        nxt();
        s_bvalid = 0;
        #1;
        chk("wr_idle_bvalid", 64'(m1_bvalid), 64'd0);

        // ---- partial write does not block read; full write beats m0 read ----
        nxt();
        m1_awaddr = 32'h8000_2000; m1_awvalid = 1; m1_wvalid = 0;
        m0_araddr = 32'h8000_0010; m0_arvalid = 1;
        s_arready = 1; s_rvalid = 1;
        #1;
        chk("part_m0_arready", 64'(m0_arready), 64'd1);
        chk("part_m1_awready", 64'(m1_awready), 64'd0);
        nxt();
        m0_araddr = 32'h8000_0020; m1_wvalid = 1;
        #1;
        chk("part_busy_awready", 64'(m1_awready), 64'd0);
        chk("part_busy_arready", 64'(m0_arready), 64'd0);
        nxt();
        #1 chk("part_m0_rvalid", 64'(m0_rvalid), 64'd1);
        nxt();
        #1;
        chk("prio_wr_awready", 64'(m1_awready), 64'd1);
        chk("prio_wr_wready", 64'(m1_wready), 64'd1);
        chk("prio_m0_arready", 64'(m0_arready), 64'd0);
        nxt();
        m1_awvalid = 0; m1_wvalid = 0; s_awready = 1; s_wready = 1; s_bvalid = 1; s_bresp = 2'b00;
        #1 chk("prio_s_awaddr", 64'(s_awaddr), 64'h8000_2000);
        nxt();
        #1 chk("prio_bvalid", 64'(m1_bvalid), 64'd1);
        nxt();
        s_bvalid = 0; s_awready = 0; s_wready = 0;
        m0_rready = 0;
        #1 chk("prio_pending_m0_arready", 64'(m0_arready), 64'd1);

        // ---- backpressure then reset in RDATA ----
        nxt();
        m0_arvalid = 0;
        #1 chk("bp_s_araddr", 64'(s_araddr), 64'h8000_0020);
        for (int i = 0; i < 5; i++) begin
            nxt();
            #1;
            chk("bp_m0_rvalid", 64'(m0_rvalid), 64'd1);
            chk("bp_s_rready", 64'(s_rready), 64'd0);
        end
        nxt();
        rst = 1;
        #1 chk("midrst_outputs_zero", 64'(any_out), 64'd0);
        nxt();
        rst = 0; m0_rready = 1;
        #1;
        chk("midrst_m0_rvalid", 64'(m0_rvalid), 64'd0);
        chk("midrst_s_arvalid", 64'(s_arvalid), 64'd0);
        chk("midrst_s_rready", 64'(s_rready), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
